// File: rtl/ring_evt_seq.sv
// ring_evt_seq: waits for an event in every channel's L1A buffer, drains each ring
// in channel order into the event FIFO under back-pressure, then retires the event.
module ring_evt_seq #(
    parameter int NCHAN = 6,
    parameter int WPS   = 16,
    parameter int TMO   = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       SAMP_MAX,
    input  logic [NCHAN-1:0] L1A_BUF_MT,
    input  logic [NCHAN-1:0] RING_AMT,
    input  logic             EVT_BUF_AFL,
    output logic [NCHAN-1:0] LD_ADDR,
    output logic [NCHAN-1:0] RD,
    output logic [NCHAN-1:0] NXT_L1A,
    output logic [2:0]       CH_SEL,
    output logic             EVT_DONE,
    output logic             BUSY,
    output logic [15:0]      EVT_CNT,
    output logic             SKEW_ERR,
    output logic [2:0]       STATE
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_POP  = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;
    localparam logic [11:0] WPS_W = 12'(WPS);
    localparam logic [7:0]  TMO_W = 8'(TMO);
    localparam logic [NCHAN-1:0] ONE = {{(NCHAN-1){1'b0}}, 1'b1};

    logic [2:0]  state_q, state_d;
    logic [2:0]  ch_q, ch_d;
    logic [11:0] wcnt_q, wcnt_d;
    logic [11:0] total_q, total_d;
    logic [7:0]  skew_q, skew_d;
    logic        skew_err_q, skew_err_d;
    logic [15:0] evt_cnt_q, evt_cnt_d;
    logic        all_rdy, partial, rd_en, last_word, last_ch;
    logic [NCHAN-1:0] ch_oh;

    always_comb begin
        all_rdy    = L1A_BUF_MT == '0;
        partial    = !all_rdy && (L1A_BUF_MT != '1);
        rd_en      = (state_q == S_READ) && !RING_AMT[ch_q] && !EVT_BUF_AFL;
        last_word  = wcnt_q == total_q - 12'd1;
        last_ch    = ch_q == 3'(NCHAN - 1);
        ch_oh      = ONE << ch_q;
        state_d    = state_q;
        ch_d       = ch_q;
        wcnt_d     = wcnt_q;
        total_d    = total_q;
        evt_cnt_d  = evt_cnt_q;
        case (state_q)
            S_IDLE: if (all_rdy && !EVT_BUF_AFL) begin
                total_d = {5'd0, SAMP_MAX} * WPS_W;
                ch_d    = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                wcnt_d  = '0;
                state_d = (total_q == '0) ? S_NEXT : S_READ;
            end
            S_READ: if (rd_en) begin
                wcnt_d  = wcnt_q + 12'd1;
                state_d = last_word ? S_NEXT : S_READ;
            end
            S_NEXT: begin
                state_d = last_ch ? S_POP : S_LOAD;
                ch_d    = last_ch ? ch_q : ch_q + 3'd1;
            end
            S_POP: begin
                evt_cnt_d = evt_cnt_q + 16'd1;
                state_d   = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
        // saturate so a long skew cannot wrap the counter back under the threshold
        skew_d     = (state_q == S_IDLE && partial) ? ((skew_q == TMO_W) ? skew_q : skew_q + 8'd1) : '0;
        skew_err_d = skew_err_q | (skew_d == TMO_W);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            wcnt_q     <= '0;
            total_q    <= '0;
            skew_q     <= '0;
            skew_err_q <= 1'b0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            wcnt_q     <= wcnt_d;
            total_q    <= total_d;
            skew_q     <= skew_d;
            skew_err_q <= skew_err_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign LD_ADDR  = (state_q == S_LOAD) ? ch_oh : '0;
    assign RD       = rd_en ? ch_oh : '0;
    assign NXT_L1A  = (state_q == S_POP) ? '1 : '0;
    assign EVT_DONE = state_q == S_POP;
    assign BUSY     = state_q != S_IDLE;
    assign CH_SEL   = ch_q;
    assign EVT_CNT  = evt_cnt_q;
    assign SKEW_ERR = skew_err_q;
    assign STATE    = state_q;
endmodule

// File: tb/tb_ring_evt_seq.sv
// tb_ring_evt_seq: scoreboard bench; expected per-event results are queued when an
// event is presented and checked by a monitor when the sequencer returns to IDLE.
module tb_ring_evt_seq;
    logic       clk;
    logic       RST;
    logic [6:0] SAMP_MAX;
    logic [5:0] L1A_BUF_MT, RING_AMT, LD_ADDR, RD, NXT_L1A;
    logic       EVT_BUF_AFL, EVT_DONE, BUSY, SKEW_ERR;
    logic [2:0] CH_SEL, STATE;
    logic [15:0] EVT_CNT;

    typedef struct {
        int tot;
        int len;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int mcnt = 0;

    ring_evt_seq dut (
        .CLK(clk), .RST(RST), .SAMP_MAX(SAMP_MAX), .L1A_BUF_MT(L1A_BUF_MT),
        .RING_AMT(RING_AMT), .EVT_BUF_AFL(EVT_BUF_AFL), .LD_ADDR(LD_ADDR), .RD(RD),
        .NXT_L1A(NXT_L1A), .CH_SEL(CH_SEL), .EVT_DONE(EVT_DONE), .BUSY(BUSY),
        .EVT_CNT(EVT_CNT), .SKEW_ERR(SKEW_ERR), .STATE(STATE)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // monitor: accumulates per-event observations and compares on return to IDLE
    initial begin
        int len, ld_seen, ld_cyc, ld_bad, gap_bad, bp_bad, sel_bad, ex_bad, nxt_n, done_n, act;
        int rd_cnt[6];
        bit prev_busy, want;
        exp_t e;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (RST) begin
                prev_busy = 0;
            end else begin
                if (BUSY && !prev_busy) begin
                    len = 0; ld_seen = 0; ld_cyc = 0; ld_bad = 0; gap_bad = 0; bp_bad = 0;
                    sel_bad = 0; ex_bad = 0; nxt_n = 0; done_n = 0;
                    for (int c = 0; c < 6; c++) rd_cnt[c] = 0;
                    if (STATE != 3'd1 || LD_ADDR != 6'd1) ld_bad++;
                end
                if (BUSY) len++;
                act = int'(LD_ADDR != 0) + int'(RD != 0) + int'(NXT_L1A != 0);
                if (act > 1) ex_bad++;
                if (LD_ADDR != 0) begin
                    if (ld_seen > 5 || LD_ADDR != 6'(1 << ld_seen) || int'(CH_SEL) != ld_seen) ld_bad++;
                    ld_seen++;
                    ld_cyc = len;
                end
                if (RD != 0) begin
                    if (CH_SEL > 3'd5 || RD != 6'(1 << CH_SEL)) sel_bad++;
                    else begin
                        if (rd_cnt[CH_SEL] == 0 && len - ld_cyc != 1) gap_bad++;
                        rd_cnt[CH_SEL]++;
                    end
                end
                want = (STATE == 3'd2) && !EVT_BUF_AFL && (CH_SEL < 3'd6) && !RING_AMT[CH_SEL];
                if ((RD != 0) != want) bp_bad++;
                if (NXT_L1A != 0) begin
                    nxt_n++;
                    if (NXT_L1A != 6'h3F || !EVT_DONE) ex_bad++;
                end
                if (EVT_DONE) done_n++;
                if (!BUSY && prev_busy) begin
                    if (exp_q.size() == 0) chk("sb_empty", 0, 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("evt_len", len, e.len);
                        chk("evt_cnt", int'(EVT_CNT), e.cnt);
                        for (int c = 0; c < 6; c++) chk($sformatf("rd_ch%0d", c), rd_cnt[c], e.tot);
                        chk("ld_count", ld_seen, 6);
                        chk("ld_order", ld_bad, 0);
                        chk("first_rd_gap", gap_bad, 0);
                        chk("backpressure", bp_bad, 0);
                        chk("rd_onehot", sel_bad, 0);
                        chk("exclusive", ex_bad, 0);
                        chk("nxt_pulses", nxt_n, 1);
                        chk("done_pulses", done_n, 1);
                    end
                end
                prev_busy = BUSY;
            end
        end
    end

    task automatic run_event(input int samp, input int new_samp, input int afl_len,
                             input int amt_len, input int other_len);
        int in2, in3;
        bit seen;
        logic [5:0] amt;
        exp_t e;
        mcnt++;
        e.tot = samp * 16;
        e.len = 6 * (e.tot + 2) + 2 + afl_len + amt_len;
        e.cnt = mcnt;
        exp_q.push_back(e);
        SAMP_MAX = 7'(samp);
        L1A_BUF_MT = '0;
        EVT_BUF_AFL = 0;
        in2 = 0; in3 = 0; seen = 0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(posedge clk); #1;
            if (NXT_L1A != 0) seen = 1;
            else begin
                if (STATE == 3'd2 && CH_SEL == 3'd2) in2++;
                if (STATE == 3'd2 && CH_SEL == 3'd3) in3++;
                EVT_BUF_AFL = afl_len > 0 && in3 >= 5 && in3 < 5 + afl_len;
                amt = '0;
                if (amt_len > 0 && in2 >= 3 && in2 < 3 + amt_len) amt[2] = 1'b1;
                if (other_len > 0 && in2 >= 8 && in2 < 8 + other_len) amt = amt | 6'b111011;
                RING_AMT = amt;
                if (new_samp >= 0 && STATE == 3'd2 && CH_SEL == 3'd1) SAMP_MAX = 7'(new_samp);
            end
        end
        if (!seen) chk("evt_timeout", 0, 1);
        L1A_BUF_MT = '1;
        EVT_BUF_AFL = 0;
        RING_AMT = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bit busy_seen, found;
        RST = 1; SAMP_MAX = 0; L1A_BUF_MT = '1; RING_AMT = '0; EVT_BUF_AFL = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(STATE), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_strobes", int'({LD_ADDR, RD, NXT_L1A}), 0);
        chk("rst_cnt", int'(EVT_CNT), 0);
        chk("rst_skew", int'(SKEW_ERR), 0);
        RST = 0;
        repeat (2) @(posedge clk);
        #1;
        run_event(8, -1, 0, 0, 0);
        chk("no_skew", int'(SKEW_ERR), 0);
        run_event(8, -1, 10, 0, 0);
        // all buffers ready but event FIFO almost full: must not start
        EVT_BUF_AFL = 1; SAMP_MAX = 0; L1A_BUF_MT = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("afl_idle", int'(STATE), 0);
        run_event(0, -1, 0, 0, 0);
        run_event(1, -1, 0, 4, 5);
        run_event(8, 4, 0, 0, 0);
        run_event(4, -1, 0, 0, 0);
        chk("no_skew2", int'(SKEW_ERR), 0);
        L1A_BUF_MT = 6'b000001;
        busy_seen = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (BUSY) busy_seen = 1;
            if (i == 250) chk("skew_early", int'(SKEW_ERR), 0);
            if (i == 260) chk("skew_set", int'(SKEW_ERR), 1);
        end
        chk("skew_noload", int'(busy_seen), 0);
        run_event(2, -1, 0, 0, 0);
        chk("skew_sticky", int'(SKEW_ERR), 1);
        SAMP_MAX = 8; L1A_BUF_MT = '0;
        found = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(posedge clk); #1;
            if (STATE == 3'd2 && CH_SEL == 3'd2) found = 1;
        end
        chk("reach_ch2", int'(found), 1);
        repeat (10) @(posedge clk);
        #1;
        RST = 1; L1A_BUF_MT = '1;
        @(posedge clk); #1;
        chk("mid_rst_state", int'(STATE), 0);
        chk("mid_rst_strobes", int'({LD_ADDR, RD, NXT_L1A}), 0);
        chk("mid_rst_misc", int'({CH_SEL, EVT_DONE, BUSY, SKEW_ERR}), 0);
        chk("mid_rst_cnt", int'(EVT_CNT), 0);
        RST = 0;
        mcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        run_event(1, -1, 0, 0, 0);
        repeat (4) @(posedge clk);
        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ring_evt_seq.md
# ring_evt_seq

Event readout sequencer for a DCFEB with one `ringbuf` per ADC channel group.
- It waits until every channel's L1A buffer holds an event.
- It then drains each channel's ring in fixed order (channel 0 first) into the shared event FIFO, honouring FIFO almost-full and ring almost-empty back-pressure.
- It then retires the event from all L1A buffers at once.
- It sits between the per-channel ring buffers and the event builder, and replaces the per-ring local transfer FSMs.

## Interface
Parameters:
- NCHAN, 6, number of ring buffers sequenced
- WPS, 16, 12-bit words per sample per channel
- TMO, 255, cycles of partial L1A occupancy before skew error

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- SAMP_MAX  in  7  samples per event; latched at event start
- L1A_BUF_MT  in  NCHAN  per-channel L1A buffer empty
- RING_AMT  in  NCHAN  per-channel ring almost-empty (<7 words readable)
- EVT_BUF_AFL  in  1  event FIFO almost full
- LD_ADDR  out  NCHAN  one-hot; load ring read pointer from L1A start address
- RD  out  NCHAN  one-hot; advance ring read pointer (one word)
- NXT_L1A  out  NCHAN  pop all L1A buffers (all bits together)
- CH_SEL  out  3  index of channel being read (data mux select)
- EVT_DONE  out  1  one-cycle pulse per completed event
- BUSY  out  1  high whenever state != IDLE
- EVT_CNT  out  16  completed-event count, wraps
- SKEW_ERR  out  1  sticky; channels disagree on event availability
- STATE  out  3  IDLE=0, LOAD=1, READ=2, NEXT=3, POP=4, GAP=5

## Operation
- Reset: all outputs 0, state IDLE, ch=0, wcnt=0, skew counter 0.
- IDLE:
  - If all L1A_BUF_MT=0 and EVT_BUF_AFL=0: latch total=SAMP_MAX*WPS (12-bit, max 2032), set ch=0, go to LOAD.
  - If all L1A_BUF_MT=0 but EVT_BUF_AFL=1: remain in IDLE.
- LOAD:
  - LD_ADDR[ch]=1 for exactly this cycle; wcnt←0.
  - If total==0, go to NEXT; otherwise go to READ.
- READ:
  - RD[ch] = (state==READ) & !RING_AMT[ch] & !EVT_BUF_AFL. This is combinational from the state register and inputs.
  - Each RD cycle: wcnt←wcnt+1.
  - When RD is high and wcnt==total-1, go to NEXT.
  - Stall cycles hold state and wcnt; there is no limit on stall length.
- NEXT: if ch==NCHAN-1, go to POP; else ch←ch+1 and go to LOAD.
- POP:
  - NXT_L1A = all ones for one cycle.
  - EVT_DONE=1 for one cycle; EVT_CNT←EVT_CNT+1 (wraps 0xFFFF→0).
  - Go to GAP.
- GAP: one idle cycle so empty flags settle; then go to IDLE.
- Skew detection:
  - In IDLE, while L1A_BUF_MT is neither all-0 nor all-1, an 8-bit counter increments; otherwise the counter clears.
  - When the counter reaches TMO, SKEW_ERR←1. SKEW_ERR stays set until RST.
  - Sequencing continues normally.
- SAMP_MAX changes mid-event are ignored; the new value applies at the next IDLE→LOAD transition.
- CH_SEL = ch at all times.
- LD_ADDR, RD and NXT_L1A are never active in the same cycle.
- RST asserted mid-event: all outputs are 0 on the following cycle. Partially read rings are not popped; the owner resets the FIFOs alongside.

## Timing
- Event start: L1A_BUF_MT goes all-0 at cycle N while in IDLE.
  - LOAD (LD_ADDR[0]) at N+1.
  - First possible RD[0] at N+2.
- Per channel with no stalls: 1 LOAD cycle + total READ cycles + 1 NEXT cycle.
- Unstalled event length from IDLE exit to IDLE re-entry: NCHAN*(total+2)+2 cycles.
- Back-pressure: EVT_BUF_AFL or RING_AMT[ch] high at cycle k gives RD=0 at cycle k (same cycle, no pipeline). The FIFO AFL threshold must leave ≥3 words of margin for the downstream 2-stage push pipeline.
- NXT_L1A and EVT_DONE are coincident. L1A_BUF_MT is next evaluated no earlier than 2 cycles after them.

## Test plan
- Single event, NCHAN=6, WPS=16, SAMP_MAX=8 → 128 RD pulses per channel, channels in order 0..5. The LD_ADDR[c] pulse comes one cycle before the first RD[c]. One NXT_L1A=6'h3F, EVT_DONE=1, EVT_CNT=1; total length 782 cycles.
- EVT_BUF_AFL held high for 10 cycles mid-channel-3 → RD=0 for exactly those 10 cycles. wcnt resumes, still 128 words for channel 3, and the event takes 792 cycles.
- SAMP_MAX=0 → LD_ADDR pulses for all six channels, zero RD, one NXT_L1A; event length 14 cycles.
- L1A_BUF_MT=6'b000001 held 300 cycles → no LOAD; SKEW_ERR rises at cycle 255, stays high after the buffers align and the event reads out normally.
- RST asserted during READ of channel 2 → next cycle STATE=0, all outputs 0, EVT_CNT=0. A new event after release starts at channel 0.
- SAMP_MAX changed 8→4 during channel 1 → current event keeps 128 words per channel; next event reads 64 words per channel.
